// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode and FSM state encodings for the sequential ALU.
//               Opcode map is unchanged from the 8-bit combinational ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_SHL = 3'b100,
        OP_SHR = 3'b101,
        OP_OR  = 3'b110,
        OP_AND = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_iter
// Description : Iterative unsigned shift-add multiplier / restoring divider.
//               One step per cycle for WIDTH cycles after start.
//               lo/hi present the result of the step taken on the current
//               cycle, so the caller can register the final result on the
//               same edge that performs the last step (done=1).
// Ports       : clk, rst    - clock, synchronous active-high reset
//               start       - load operands and begin WIDTH steps
//               is_div      - 1: divide, 0: multiply (sampled at start)
//               a, b        - operands (sampled at start)
//               done        - high during the cycle of the final step
//               lo, hi      - product low/high, or quotient/remainder
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_iter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    import alu_pkg::*;

    localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_div;
    logic [WIDTH-1:0] r_lo;   // multiplier bits / dividend shifting into quotient
    logic [WIDTH-1:0] r_hi;   // partial product / partial remainder
    logic [WIDTH-1:0] r_b;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem;
    logic             w_ge;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;

    always_comb begin
        // Multiply: conditionally add b, then shift the whole {hi,lo} right.
        w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        // Divide: shift next dividend bit into the remainder and try subtract.
        w_rem = {r_hi, r_lo[WIDTH-1]};
        w_ge  = (w_rem >= {1'b0, r_b});
        if (r_div) begin
            // Remainder after a successful subtract is < b, so WIDTH bits suffice.
            w_hi = w_ge ? (w_rem[WIDTH-1:0] - r_b) : w_rem[WIDTH-1:0];
            w_lo = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            w_hi = w_sum[WIDTH:1];
            w_lo = {w_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_div <= 1'b0;
            r_lo  <= '0;
            r_hi  <= '0;
            r_b   <= '0;
        end else if (start) begin
            r_cnt <= C_CNT_INIT;
            r_div <= is_div;
            r_lo  <= a;
            r_hi  <= '0;
            r_b   <= b;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - C_CNT_ONE;
            r_lo  <= w_lo;
            r_hi  <= w_hi;
        end
    end

    assign done = (r_cnt == C_CNT_ONE);
    assign lo   = w_lo;
    assign hi   = w_hi;

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Handshaked WIDTH-bit ALU. Single-cycle add/sub/shift/logic,
//               iterative mul (full product) and div (quotient+remainder),
//               registered status flags. One operation in flight.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               in_valid, in_ready   - request handshake (ready only in IDLE)
//               a, b, sel            - operands and opcode
//               out_valid, out_ready - result handshake
//               y, y_hi              - result / product high or remainder
//               flag_z/c/v/dz        - zero, carry/borrow, mul overflow,
//                                      divide-by-zero
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_dz
);
    import alu_pkg::*;

    localparam logic [WIDTH-1:0] C_WIDTH_VAL = WIDTH'(WIDTH);

    state_e           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_is_mul;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_y_hi;
    logic             r_z;
    logic             r_c;
    logic             r_v;
    logic             r_dz;

    logic             w_accept;
    logic             w_start;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_y_hi;
    logic             w_c;
    logic             w_dz;
    logic             w_md_done;
    logic [WIDTH-1:0] w_md_lo;
    logic [WIDTH-1:0] w_md_hi;

    assign w_accept = in_valid && r_in_ready;
    // Divide by zero short-circuits to the single-cycle path.
    assign w_start  = w_accept && ((sel == OP_MUL) || ((sel == OP_DIV) && (b != '0)));

    // Single-cycle datapath, evaluated on the operands present at accept.
    always_comb begin
        w_sum  = {1'b0, a} + {1'b0, b};
        w_y    = '0;
        w_y_hi = '0;
        w_c    = 1'b0;
        w_dz   = 1'b0;
        case (sel)
            OP_ADD: begin
                w_y = w_sum[WIDTH-1:0];
                w_c = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_y = a - b;
                w_c = (a < b);
            end
            OP_DIV: begin
                w_y    = '1;
                w_y_hi = a;
                w_dz   = (b == '0);
            end
            OP_SHL:  w_y = (b >= C_WIDTH_VAL) ? '0 : (a << b);
            OP_SHR:  w_y = (b >= C_WIDTH_VAL) ? '0 : (a >> b);
            OP_OR:   w_y = a | b;
            OP_AND:  w_y = a & b;
            default: w_y = '0;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (w_start),
        .is_div (sel == OP_DIV),
        .a      (a),
        .b      (b),
        .done   (w_md_done),
        .lo     (w_md_lo),
        .hi     (w_md_hi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_is_mul    <= 1'b0;
            r_y         <= '0;
            r_y_hi      <= '0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_dz        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_is_mul   <= (sel == OP_MUL);
                        if (w_start) begin
                            r_state <= BUSY;
                        end else begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_y         <= w_y;
                            r_y_hi      <= w_y_hi;
                            r_z         <= (w_y == '0);
                            r_c         <= w_c;
                            r_v         <= 1'b0;
                            r_dz        <= w_dz;
                        end
                    end
                end
                BUSY: begin
                    // Final step's result is taken straight from the iterator.
                    if (w_md_done) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_y         <= w_md_lo;
                        r_y_hi      <= w_md_hi;
                        r_z         <= (w_md_lo == '0);
                        r_c         <= 1'b0;
                        r_v         <= r_is_mul && (w_md_hi != '0);
                        r_dz        <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign y_hi      = r_y_hi;
    assign flag_z    = r_z;
    assign flag_c    = r_c;
    assign flag_v    = r_v;
    assign flag_dz   = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq (WIDTH=8). Directed vector
//               table plus hand-written backpressure and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic [7:0] y_hi;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    logic       flag_dz;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_hi      (y_hi),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_dz   (flag_dz)
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] va;
        logic [7:0] vb;
        int         lat;
        logic [7:0] ey;
        logic [7:0] ehi;
        logic       ez;
        logic       ec;
        logic       ev;
        logic       edz;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Issue one op, measure accept-to-out_valid latency, check every output,
    // then confirm return to IDLE (out_ready assumed high).
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        int busy_bad;
        @(negedge clk);
        in_valid = 1'b1;
        a        = v.va;
        b        = v.vb;
        sel      = v.op;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        busy_bad = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready !== 1'b0) busy_bad++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency",       idx, lat,       v.lat);
        chk("in_ready_busy", idx, busy_bad,  0);
        chk("in_ready_done", idx, in_ready,  0);
        chk("y",             idx, y,         v.ey);
        chk("y_hi",          idx, y_hi,      v.ehi);
        chk("flag_z",        idx, flag_z,    v.ez);
        chk("flag_c",        idx, flag_c,    v.ec);
        chk("flag_v",        idx, flag_v,    v.ev);
        chk("flag_dz",       idx, flag_dz,   v.edz);
        @(posedge clk);
        #1;
        chk("idle_out_valid", idx, out_valid, 0);
        chk("idle_in_ready",  idx, in_ready,  1);
    endtask

    initial begin
        int bad;
        //          op      a      b     lat  y      y_hi   z     c     v     dz
        vecs[0]  = '{3'b000, 8'hF0, 8'h20, 1, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{3'b001, 8'h05, 8'h07, 1, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{3'b001, 8'h07, 8'h07, 1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'b010, 8'd200, 8'd3, 9, 8'h58, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{3'b011, 8'd100, 8'd7, 9, 8'h0E, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'b011, 8'h37, 8'h00, 1, 8'hFF, 8'h37, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{3'b100, 8'h81, 8'd1, 1, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b100, 8'h81, 8'd9, 1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'b101, 8'h80, 8'd7, 1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'b110, 8'h5A, 8'h0F, 1, 8'h5F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3'b111, 8'h5A, 8'h0F, 1, 8'h0A, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{3'b010, 8'h0F, 8'h00, 9, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{3'b011, 8'hFF, 8'h01, 9, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{3'b000, 8'hFF, 8'h01, 1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{3'b010, 8'hFF, 8'hFF, 9, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{3'b011, 8'd7, 8'd100, 9, 8'h00, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{3'b101, 8'h80, 8'd8, 1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{3'b000, 8'h12, 8'h34, 1, 8'h46, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sel       = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  0, in_ready,  1);
        chk("rst_out_valid", 0, out_valid, 0);
        chk("rst_y",         0, y,         0);
        chk("rst_y_hi",      0, y_hi,      0);
        chk("rst_flags",     0, {flag_z, flag_c, flag_v, flag_dz}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

        // Backpressure: result held 5 cycles while new requests are offered.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 8'h10; b = 8'h20; sel = 3'b000;
        @(posedge clk);
        #1;
        a = 8'hAA; b = 8'h03; sel = 3'b010;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== 8'h30 || y_hi !== 8'h00 ||
                {flag_z, flag_c, flag_v, flag_dz} !== 4'b0000) bad++;
            @(posedge clk);
            #1;
        end
        chk("bp_hold", 0, bad, 0);
        chk("bp_y_after", 0, y, 8'h30);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", 0, out_valid, 0);
        chk("bp_release_in_ready",  0, in_ready,  1);
        @(posedge clk);
        #1;
        chk("bp_nothing_accepted", 0, {in_ready, out_valid}, 2'b10);

        // Reset during a divide: the op is dropped with no output.
        @(negedge clk);
        in_valid = 1'b1;
        a = 8'd100; b = 8'd7; sel = 3'b011;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready",  0, in_ready,  1);
        chk("midrst_out_valid", 0, out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        chk("midrst_no_output", 0, bad, 0);

        // Reset coincident with a request: nothing accepted.
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        a = 8'h01; b = 8'h01; sel = 3'b000;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_vs_valid", 0, {in_ready, out_valid}, 2'b10);

        // Recovery after reset.
        run_vec(vecs[3], 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
